// File: rtl/pim_req_arbiter_if.sv
// Request/response bundle around pim_req_arbiter: s_* faces the requesters, m_* faces the DRAM controller.
// Modport slave is the arbiter's view; master is the view of the surrounding system.
interface pim_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 512
);
    logic [NUM_REQ-1:0]        s_req_valid;
    logic [NUM_REQ-1:0]        s_req_ready;
    logic [NUM_REQ*ADDR_W-1:0] s_req_addr;
    logic [NUM_REQ-1:0]        s_resp_valid;
    logic [NUM_REQ-1:0]        s_resp_ready;
    logic [DATA_W-1:0]         s_resp_data;
    logic                      m_req_valid;
    logic                      m_req_ready;
    logic [ADDR_W-1:0]         m_req_addr;
    logic                      m_resp_valid;
    logic                      m_resp_ready;
    logic [DATA_W-1:0]         m_resp_data;

    modport slave (
        input  s_req_valid, s_req_addr, s_resp_ready,
        input  m_req_ready, m_resp_valid, m_resp_data,
        output s_req_ready, s_resp_valid, s_resp_data,
        output m_req_valid, m_req_addr, m_resp_ready
    );

    modport master (
        output s_req_valid, s_req_addr, s_resp_ready,
        output m_req_ready, m_resp_valid, m_resp_data,
        input  s_req_ready, s_resp_valid, s_resp_data,
        input  m_req_valid, m_req_addr, m_resp_ready
    );
endinterface

// File: rtl/pim_req_arbiter.sv
// Shares one DRAM controller request/response port among NUM_REQ requesters, routing responses in order.
// Define PIM_ARB_ROW_HIT_EN to add open-row-hit priority between the starvation override and round-robin.
module pim_req_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 512,
    parameter int ROW_LSB    = 13,
    parameter int ROW_W      = 14,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    pim_req_arbiter_if.slave       bus,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   resp_err
);
    localparam int GW  = $clog2(NUM_REQ);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WCW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0]  DEPTH_CNT  = CW'(DEPTH);
    localparam logic [WCW-1:0] STARVE_CNT = WCW'(STARVE_MAX);
    localparam logic [GW-1:0]  LAST_REQ   = GW'(NUM_REQ - 1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [GW-1:0]     r_gnt;
    logic [GW-1:0]     r_rr_ptr;
    logic [ADDR_W-1:0] r_addr;
    logic [WCW-1:0]    r_wait_cnt [NUM_REQ];
    logic [GW-1:0]     r_tag_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_resp_err;
    logic [GW-1:0]     w_win;
    logic [GW-1:0]     w_head;
    logic              w_arb_go;
    logic              w_fire;
    logic              w_pop;
    logic              w_empty;
    logic [DATA_W-1:0] w_resp_data;
`ifdef PIM_ARB_ROW_HIT_EN
    logic [ROW_W-1:0]  r_last_row;
    logic              r_row_vld;
`endif

    if (ROW_LSB + ROW_W > ADDR_W) begin : g_row_field_check
        $error("pim_req_arbiter: row field does not fit inside ADDR_W");
    end

    // Circular scan from r_rr_ptr; the first match at each priority level wins.
    always_comb begin
        logic          found_st;
        logic          found_v;
        logic [GW-1:0] win_st;
        logic [GW-1:0] win_v;
        logic [GW-1:0] idx_g;
        int unsigned   idx;
`ifdef PIM_ARB_ROW_HIT_EN
        logic          found_hit;
        logic [GW-1:0] win_hit;
        found_hit = 1'b0;
        win_hit   = '0;
`endif
        found_st = 1'b0;
        found_v  = 1'b0;
        win_st   = '0;
        win_v    = '0;
        idx_g    = '0;
        idx      = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            idx_g = GW'(idx);
            if (bus.s_req_valid[idx_g]) begin
                if (!found_v) begin
                    found_v = 1'b1;
                    win_v   = idx_g;
                end
                if (!found_st && r_wait_cnt[idx_g] == STARVE_CNT) begin
                    found_st = 1'b1;
                    win_st   = idx_g;
                end
`ifdef PIM_ARB_ROW_HIT_EN
                if (!found_hit && r_row_vld &&
                    bus.s_req_addr[32'(idx_g) * ADDR_W + ROW_LSB +: ROW_W] == r_last_row) begin
                    found_hit = 1'b1;
                    win_hit   = idx_g;
                end
`endif
            end
        end
        w_win = win_v;
`ifdef PIM_ARB_ROW_HIT_EN
        if (found_hit) w_win = win_hit;
`endif
        if (found_st) w_win = win_st;
    end

    assign w_arb_go = (|bus.s_req_valid) && (r_count < DEPTH_CNT);
    assign w_fire   = (r_state == ISSUE) && bus.m_req_ready;
    assign w_empty  = (r_count == '0);
    assign w_head   = r_tag_mem[r_rd_ptr];
    assign w_pop    = bus.m_resp_valid && bus.m_resp_ready;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_arb_go) w_state_nxt = ISSUE;
            ISSUE:   if (bus.m_req_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.m_req_valid = (r_state == ISSUE);
        bus.m_req_addr  = r_addr;
        bus.s_req_ready = '0;
        if (w_fire) bus.s_req_ready[r_gnt] = 1'b1;
    end

    always_comb begin
        bus.s_resp_valid         = '0;
        bus.s_resp_valid[w_head] = bus.m_resp_valid && !w_empty;
        bus.m_resp_ready         = bus.s_resp_ready[w_head] && !w_empty;
    end

    assign w_resp_data     = bus.m_resp_data;
    assign bus.s_resp_data = w_resp_data;

    always_ff @(posedge clk) begin
        if (w_fire) r_tag_mem[r_wr_ptr] <= r_gnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt      <= '0;
            r_rr_ptr   <= '0;
            r_addr     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_resp_err <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) r_wait_cnt[i] <= '0;
`ifdef PIM_ARB_ROW_HIT_EN
            r_last_row <= '0;
            r_row_vld  <= 1'b0;
`endif
        end else begin
            if (r_state == IDLE && w_arb_go) begin
                r_gnt  <= w_win;
                r_addr <= bus.s_req_addr[32'(w_win) * ADDR_W +: ADDR_W];
            end
            if (w_fire) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_rr_ptr <= (r_gnt == LAST_REQ) ? '0 : r_gnt + 1'b1;
                for (int unsigned i = 0; i < NUM_REQ; i++) begin
                    if (GW'(i) == r_gnt)
                        r_wait_cnt[i] <= '0;
                    else if (bus.s_req_valid[i] && r_wait_cnt[i] != STARVE_CNT)
                        r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
                end
`ifdef PIM_ARB_ROW_HIT_EN
                r_last_row <= r_addr[ROW_LSB +: ROW_W];
                r_row_vld  <= 1'b1;
`endif
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_fire, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.m_resp_valid && w_empty) r_resp_err <= 1'b1;
        end
    end

    assign outstanding = r_count;
    assign resp_err    = r_resp_err;
endmodule

// File: tb/tb_pim_req_arbiter.sv
// Directed bench for pim_req_arbiter (default build): issue latency, round-robin order, starvation override,
// tag FIFO full/backpressure, in-order response routing, error flag and mid-issue reset.
module tb_pim_req_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] outstanding;
    logic       resp_err;
    int         n_checks = 0;
    int         n_errors = 0;

    logic [31:0] addr_tbl [4] = '{32'h0000_2000, 32'h0000_4040, 32'h0000_6080, 32'h0000_80C0};
    int unsigned rr_seq [5]   = '{0, 1, 2, 3, 0};

    pim_req_arbiter_if #(.NUM_REQ(4), .ADDR_W(32), .DATA_W(512)) bus ();

    // Four round-robin requesters never wait more than three grants, so a threshold of 1 exposes the override.
    pim_req_arbiter #(
        .NUM_REQ(4), .ADDR_W(32), .DATA_W(512), .ROW_LSB(13), .ROW_W(14), .DEPTH(4), .STARVE_MAX(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        bus.s_req_valid  = '0;
        bus.s_resp_ready = '0;
        bus.m_req_ready  = 1'b1;
        bus.m_resp_valid = 1'b0;
        bus.m_resp_data  = {8{64'h0123_4567_89AB_CDEF}};
        bus.s_req_addr   = {addr_tbl[3], addr_tbl[2], addr_tbl[1], addr_tbl[0]};
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Present vld in IDLE, expect requester g to be issued and accepted, then drop all valids.
    task automatic grant(input logic [3:0] vld, input int unsigned g, input string tag);
        bus.s_req_valid = vld;
        tick();
        check({tag, ".m_req_valid"}, 64'(bus.m_req_valid), 64'd1);
        check({tag, ".m_req_addr"}, 64'(bus.m_req_addr), 64'(addr_tbl[g]));
        check({tag, ".s_req_ready"}, 64'(bus.s_req_ready), 64'(4'b0001 << g));
        tick();
        bus.s_req_valid = '0;
    endtask

    task automatic resp(input logic [3:0] rdy, input logic [3:0] exp_v, input logic exp_mr, input string tag);
        bus.m_resp_valid = 1'b1;
        bus.s_resp_ready = rdy;
        #1;
        check({tag, ".s_resp_valid"}, 64'(bus.s_resp_valid), 64'(exp_v));
        check({tag, ".m_resp_ready"}, 64'(bus.m_resp_ready), 64'(exp_mr));
        check({tag, ".s_resp_data"}, bus.s_resp_data[511:448], 64'h0123_4567_89AB_CDEF);
        tick();
        bus.m_resp_valid = 1'b0;
    endtask

    initial begin
        // Reset state and single request.
        do_reset();
        check("rst.m_req_valid", 64'(bus.m_req_valid), 64'd0);
        check("rst.m_req_addr", 64'(bus.m_req_addr), 64'd0);
        check("rst.s_req_ready", 64'(bus.s_req_ready), 64'd0);
        check("rst.s_resp_valid", 64'(bus.s_resp_valid), 64'd0);
        check("rst.outstanding", 64'(outstanding), 64'd0);
        check("rst.resp_err", 64'(resp_err), 64'd0);
        grant(4'b0001, 0, "single");
        check("single.outstanding", 64'(outstanding), 64'd1);
        check("single.idle_valid", 64'(bus.m_req_valid), 64'd0);

        // Push and pop on the same edge keep the occupancy at one.
        bus.s_req_valid = 4'b0010;
        tick();
        bus.m_resp_valid = 1'b1;
        bus.s_resp_ready = 4'b1111;
        #1;
        check("pushpop.s_resp_valid", 64'(bus.s_resp_valid), 64'h1);
        check("pushpop.s_req_ready", 64'(bus.s_req_ready), 64'h2);
        tick();
        bus.m_resp_valid = 1'b0;
        bus.s_req_valid  = '0;
        check("pushpop.outstanding", 64'(outstanding), 64'd1);
        resp(4'b1111, 4'b0010, 1'b1, "pushpop.r1");
        check("pushpop.drained", 64'(outstanding), 64'd0);

        // Round-robin with all four requesters valid.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            grant(4'b1111, rr_seq[k], $sformatf("rr%0d", k));
            resp(4'b1111, 4'(4'b0001 << rr_seq[k]), 1'b1, $sformatf("rr%0d.resp", k));
        end

        // Starvation: req3 loses once to req0 and then beats req1, which plain round-robin would pick.
        do_reset();
        grant(4'b1001, 0, "starve0");
        grant(4'b1010, 3, "starve1");
        grant(4'b1001, 0, "starve2");
        check("starve.outstanding", 64'(outstanding), 64'd3);

        // Full FIFO blocks a fifth issue; responses route in issue order 2,0,1,3.
        do_reset();
        grant(4'b0100, 2, "full0");
        grant(4'b0001, 0, "full1");
        grant(4'b0010, 1, "full2");
        grant(4'b1000, 3, "full3");
        check("full.outstanding", 64'(outstanding), 64'd4);
        bus.s_req_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("full.blocked%0d", k), 64'(bus.m_req_valid), 64'd0);
        end
        bus.s_req_valid = '0;
        resp(4'b1011, 4'b0100, 1'b0, "stall");
        check("stall.outstanding", 64'(outstanding), 64'd4);
        resp(4'b1111, 4'b0100, 1'b1, "tag2");
        resp(4'b1111, 4'b0001, 1'b1, "tag0");
        resp(4'b1111, 4'b0010, 1'b1, "tag1");
        resp(4'b1111, 4'b1000, 1'b1, "tag3");
        check("drain.outstanding", 64'(outstanding), 64'd0);
        check("drain.resp_err", 64'(resp_err), 64'd0);

        // Response with an empty FIFO, then reset in the middle of a held issue.
        do_reset();
        bus.m_resp_valid = 1'b1;
        bus.s_resp_ready = 4'b1111;
        #1;
        check("err.m_resp_ready", 64'(bus.m_resp_ready), 64'd0);
        check("err.s_resp_valid", 64'(bus.s_resp_valid), 64'd0);
        tick();
        bus.m_resp_valid = 1'b0;
        check("err.set", 64'(resp_err), 64'd1);
        tick();
        check("err.sticky", 64'(resp_err), 64'd1);
        grant(4'b0010, 1, "pre");
        bus.m_req_ready = 1'b0;
        bus.s_req_valid = 4'b0001;
        tick();
        check("hold0.m_req_valid", 64'(bus.m_req_valid), 64'd1);
        check("hold0.s_req_ready", 64'(bus.s_req_ready), 64'd0);
        tick();
        check("hold1.m_req_valid", 64'(bus.m_req_valid), 64'd1);
        check("hold1.m_req_addr", 64'(bus.m_req_addr), 64'(addr_tbl[0]));
        check("hold1.outstanding", 64'(outstanding), 64'd1);
        rst = 1'b1;
        tick();
        check("midrst.m_req_valid", 64'(bus.m_req_valid), 64'd0);
        check("midrst.outstanding", 64'(outstanding), 64'd0);
        check("midrst.resp_err", 64'(resp_err), 64'd0);
        rst             = 1'b0;
        bus.s_req_valid = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
